// File: rtl/hsi_frame_parser.sv
// hsi_frame_parser
//   Receive-side parser for the HSI byte stream. Frame layout is
//   control byte, length byte L, L payload bytes, CRC-8 byte. Emits a
//   one-cycle control-match strobe when a frame starts, and a CRC-match,
//   CRC-error or length-error strobe when it ends.
//
//   Optional feature macro: HSI_FRAME_TIMEOUT_EN
//     When defined, a frame in progress is aborted (len_err) after TIMEOUT
//     consecutive cycles without a valid byte.
//
// Ports
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   rx_data   in   [7:0] received byte
//   rx_valid  in   rx_data valid this cycle
//   me_ctrls  out  [4:0] strobe, bit i = frame of type i started
//   me_crc    out  strobe, received CRC matched
//   crc_err   out  strobe, received CRC mismatched
//   len_err   out  strobe, length too large or timeout abort
//   busy      out  frame in progress
module hsi_frame_parser #(
  parameter logic [7:0] CTRL0   = 8'h01,
  parameter logic [7:0] CTRL1   = 8'h02,
  parameter logic [7:0] CTRL2   = 8'h03,
  parameter logic [7:0] CTRL3   = 8'h04,
  parameter logic [7:0] CTRL4   = 8'h05,
  parameter int         MAX_LEN = 16,
  parameter int         TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [4:0] me_ctrls,
  output logic       me_crc,
  output logic       crc_err,
  output logic       len_err,
  output logic       busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LEN  = 2'd1;
  localparam logic [1:0] S_PAY  = 2'd2;
  localparam logic [1:0] S_CRC  = 2'd3;

  if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT < 1) begin : g_bad_param
    $error("hsi_frame_parser: parameter out of range");
  end

  // CRC-8, poly 0x07, MSB first, folded one byte per call
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int i = 0; i < 8; i++)
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    return c;
  endfunction

  logic [1:0] state_q, state_d;
  logic [7:0] crc_q, crc_d;
  logic [7:0] cnt_q, cnt_d;
  logic [4:0] me_ctrls_q, me_ctrls_d;
  logic       me_crc_q, me_crc_d;
  logic       crc_err_q, crc_err_d;
  logic       len_err_q, len_err_d;
  logic       busy_q, busy_d;
  logic [4:0] hit;
  logic [4:0] hit_1h;
  logic       abort;

`ifdef HSI_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  assign abort = (state_q != S_IDLE) && (tmo_q == TW'(TIMEOUT));
`else
  assign abort = 1'b0;
`endif

  assign hit = {rx_data == CTRL4, rx_data == CTRL3, rx_data == CTRL2,
                rx_data == CTRL1, rx_data == CTRL0};
  // isolate the lowest set bit so duplicate codes resolve to the lowest type
  assign hit_1h = hit & (~hit + 5'd1);

  always_comb begin
    state_d    = state_q;
    crc_d      = crc_q;
    cnt_d      = cnt_q;
    me_ctrls_d = '0;
    me_crc_d   = 1'b0;
    crc_err_d  = 1'b0;
    len_err_d  = 1'b0;
    if (abort) begin
      // timeout: any byte arriving this cycle is discarded
      state_d   = S_IDLE;
      cnt_d     = '0;
      len_err_d = 1'b1;
    end else if (rx_valid) begin
      case (state_q)
        S_IDLE: if (|hit) begin
          me_ctrls_d = hit_1h;
          crc_d      = crc8_byte(8'h00, rx_data);
          state_d    = S_LEN;
        end
        S_LEN: begin
          crc_d = crc8_byte(crc_q, rx_data);
          if (int'(rx_data) > MAX_LEN) begin
            len_err_d = 1'b1;
            state_d   = S_IDLE;
          end else if (rx_data == 8'h00) begin
            state_d = S_CRC;
          end else begin
            cnt_d   = rx_data;
            state_d = S_PAY;
          end
        end
        S_PAY: begin
          crc_d = crc8_byte(crc_q, rx_data);
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = S_CRC;
        end
        default: begin
          me_crc_d  = (rx_data == crc_q);
          crc_err_d = (rx_data != crc_q);
          state_d   = S_IDLE;
        end
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

`ifdef HSI_FRAME_TIMEOUT_EN
  always_comb begin
    tmo_d = '0;
    if (!abort && state_q != S_IDLE && !rx_valid) tmo_d = tmo_q + TW'(1);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      crc_q      <= '0;
      cnt_q      <= '0;
      me_ctrls_q <= '0;
      me_crc_q   <= 1'b0;
      crc_err_q  <= 1'b0;
      len_err_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      cnt_q      <= cnt_d;
      me_ctrls_q <= me_ctrls_d;
      me_crc_q   <= me_crc_d;
      crc_err_q  <= crc_err_d;
      len_err_q  <= len_err_d;
      busy_q     <= busy_d;
    end
  end

  assign me_ctrls = me_ctrls_q;
  assign me_crc   = me_crc_q;
  assign crc_err  = crc_err_q;
  assign len_err  = len_err_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_hsi_frame_parser.sv
// tb_hsi_frame_parser
//   Table of byte vectors with hand-derived expected outputs, a mid-frame
//   reset sequence, an optional timeout sequence, and random frames whose
//   CRC is computed by a bit-serial reference. Expected outputs are queued
//   as each byte is driven and popped one cycle later.
module tb_hsi_frame_parser;

  typedef struct packed {
    logic [4:0] ctrls;
    logic       mcrc;
    logic       cerr;
    logic       lerr;
    logic       busy;
  } exp_t;

  typedef struct {
    logic       v;
    logic [7:0] d;
    exp_t       e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [4:0] me_ctrls;
  logic       me_crc, crc_err, len_err, busy;

  int n_cmp = 0;
  int n_err = 0;
  exp_t sb[$];
  vec_t tbl[$];

  hsi_frame_parser #(.MAX_LEN(16), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .me_ctrls(me_ctrls), .me_crc(me_crc), .crc_err(crc_err),
    .len_err(len_err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_crc(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c = crc;
    for (int i = 7; i >= 0; i--) begin
      logic fb = c[7] ^ b[i];
      c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  function automatic exp_t mk(input logic [4:0] c, input logic m, input logic ce,
                              input logic le, input logic b);
    exp_t e;
    e.ctrls = c; e.mcrc = m; e.cerr = ce; e.lerr = le; e.busy = b;
    return e;
  endfunction

  task automatic check(input string name, input exp_t act, input exp_t req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got ctrls=%b crc=%b cerr=%b lerr=%b busy=%b, want ctrls=%b crc=%b cerr=%b lerr=%b busy=%b",
               name, act.ctrls, act.mcrc, act.cerr, act.lerr, act.busy,
               req.ctrls, req.mcrc, req.cerr, req.lerr, req.busy);
    end
  endtask

  function automatic exp_t dut_out();
    return mk(me_ctrls, me_crc, crc_err, len_err, busy);
  endfunction

  // called at a negedge: drive, push expectation, compare at next negedge
  task automatic step(input string name, input logic v, input logic [7:0] d, input exp_t e);
    exp_t req;
    rx_valid = v;
    rx_data  = d;
    sb.push_back(e);
    @(negedge clk);
    req = sb.pop_front();
    check(name, dut_out(), req);
  endtask

  task automatic add(input logic v, input logic [7:0] d, input exp_t e);
    vec_t t;
    t.v = v; t.d = d; t.e = e;
    tbl.push_back(t);
  endtask

  initial begin
    exp_t z, zb;
    z  = mk(5'b0, 0, 0, 0, 0);
    zb = mk(5'b0, 0, 0, 0, 1);

    // good frame, then back-to-back frame with bad CRC, then good again
    add(1, 8'h01, mk(5'b00001, 0, 0, 0, 1));
    add(1, 8'h00, zb);
    add(1, 8'h15, mk(5'b0, 1, 0, 0, 0));
    add(1, 8'h01, mk(5'b00001, 0, 0, 0, 1));
    add(1, 8'h00, zb);
    add(1, 8'h16, mk(5'b0, 0, 1, 0, 0));
    add(1, 8'h01, mk(5'b00001, 0, 0, 0, 1));
    add(1, 8'h00, zb);
    add(1, 8'h15, mk(5'b0, 1, 0, 0, 0));
    // length over MAX_LEN, trailing payload ignored
    add(1, 8'h02, mk(5'b00010, 0, 0, 0, 1));
    add(1, 8'h11, mk(5'b0, 0, 0, 1, 0));
    add(1, 8'hAB, z);
    add(1, 8'hCD, z);
    // junk then frame with 0..3 cycle gaps
    add(1, 8'hAA, z);
    add(0, 8'h01, z);
    add(1, 8'h7F, z);
    add(0, 8'h00, z);
    add(0, 8'h00, z);
    add(1, 8'h01, mk(5'b00001, 0, 0, 0, 1));
    add(0, 8'h01, zb);
    add(0, 8'h01, zb);
    add(0, 8'h01, zb);
    add(1, 8'h00, zb);
    add(0, 8'h15, zb);
    add(1, 8'h15, mk(5'b0, 1, 0, 0, 0));
    // type 4 frame start then invalid length
    add(1, 8'h05, mk(5'b10000, 0, 0, 0, 1));
    add(1, 8'hFF, mk(5'b0, 0, 0, 1, 0));

    repeat (2) @(negedge clk);
    check("reset_state", dut_out(), z);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("vec%0d", i), tbl[i].v, tbl[i].d, tbl[i].e);

    // mid-frame reset: outputs clear at once, trailing CRC byte ignored
    step("rst_ctrl", 1, 8'h01, mk(5'b00001, 0, 0, 0, 1));
    step("rst_len", 1, 8'h00, zb);
    rst_n = 1'b0;
    #1;
    check("rst_async", dut_out(), z);
    @(negedge clk);
    rst_n = 1'b1;
    step("rst_crc_ignored", 1, 8'h15, z);
    step("rst_idle", 0, 8'h00, z);

`ifdef HSI_FRAME_TIMEOUT_EN
    step("tmo_ctrl", 1, 8'h03, mk(5'b00100, 0, 0, 0, 1));
    step("tmo_len", 1, 8'h02, zb);
    step("tmo_pay", 1, 8'hAB, zb);
    for (int i = 0; i < 8; i++) step($sformatf("tmo_gap%0d", i), 0, 8'h00, zb);
    step("tmo_abort", 1, 8'hCD, mk(5'b0, 0, 0, 1, 0));
    step("tmo_after", 0, 8'h00, z);
`endif

    // random frames, lengths include 0 and MAX_LEN, payload may hold ctrl codes
    for (int f = 0; f < 40; f++) begin
      int t, len;
      logic [7:0] c, b, crcb;
      logic bad;
      t   = $urandom_range(0, 4);
      len = (f == 0) ? 0 : (f == 1) ? 16 : $urandom_range(0, 16);
      bad = ($urandom_range(0, 3) == 0);
      c   = ref_crc(8'h00, 8'(t + 1));
      step($sformatf("rnd%0d_ctrl", f), 1, 8'(t + 1), mk(5'(1 << t), 0, 0, 0, 1));
      for (int g = $urandom_range(0, 2); g > 0; g--) step("rnd_gap", 0, 8'h00, zb);
      c = ref_crc(c, 8'(len));
      step($sformatf("rnd%0d_len", f), 1, 8'(len), zb);
      for (int i = 0; i < len; i++) begin
        b = (i % 3 == 0) ? 8'($urandom_range(1, 5)) : 8'($urandom);
        c = ref_crc(c, b);
        if ($urandom_range(0, 3) == 0) step("rnd_gap", 0, 8'h00, zb);
        step($sformatf("rnd%0d_pay%0d", f, i), 1, b, zb);
      end
      crcb = bad ? (c ^ 8'h5A) : c;
      step($sformatf("rnd%0d_crc", f), 1, crcb, mk(5'b0, !bad, bad, 0, 0));
    end
    step("final_idle", 0, 8'h00, z);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
